// File: rtl/spram_rd_stream.sv
// Streaming block reader for the FFT single-port RAM: issues reads, absorbs the
// one-cycle RAM latency and presents words on a valid/ready stream.
// Optional bit-reversed addressing is built only when SPRAM_RD_BITREV_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; len=0 commands complete here
// RUN   | issuing reads while the 2-entry FIFO has credit
// DRAIN | all reads issued; waiting for last word to leave the FIFO
module spram_rd_stream #(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic          bitrev,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [AW-1:0] offset;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   idx_q, idx_d;
  logic          inflight_q, inflight_d;
  logic          done_q, done_d;
  logic [DW-1:0] fifo_q [2];
  logic [DW-1:0] fifo_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop;
  logic          issue;
  logic [2:0]    occ;

`ifdef SPRAM_RD_BITREV_EN
  localparam int SW = $clog2(AW + 1);

  logic          brev_q, brev_d, brev_start;
  logic [SW-1:0] shift_q, shift_d, shift_start;
  logic [AW-1:0] idx_rev;

  // Reverse the full AW-bit index, then shift down so only the low k bits remain.
  always_comb begin
    brev_start  = bitrev && (len > (AW+1)'(1)) && ((len & (len - (AW+1)'(1))) == '0);
    shift_start = '0;
    for (int j = 0; j < AW; j++) begin
      if (len[j]) shift_start = SW'(AW - j);
    end
    for (int j = 0; j < AW; j++) begin
      idx_rev[j] = idx_q[AW-1-j];
    end
    offset  = brev_q ? (idx_rev >> shift_q) : idx_q[AW-1:0];
    brev_d  = brev_q;
    shift_d = shift_q;
    if (state_q == IDLE && start) begin
      brev_d  = brev_start;
      shift_d = shift_start;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      brev_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      brev_q  <= brev_d;
      shift_q <= shift_d;
    end
  end
`else
  logic bitrev_unused;
  assign bitrev_unused = bitrev;
  assign offset        = idx_q[AW-1:0];
`endif

  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = fifo_q[rd_ptr_q];
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign ram_we  = 1'b0;
  assign ram_addr = ram_addr_d;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    issue    = 1'b0;
    pop      = m_valid && m_ready;
    // Credit: words buffered plus the read still in flight, after this cycle's pop.
    occ      = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d = base;
          len_d  = len;
          idx_d  = '0;
          if (len == '0) done_d = 1'b1;
          else           state_d = RUN;
        end
      end
      RUN: begin
        if (occ < 3'd2) begin
          issue = 1'b1;
          idx_d = idx_q + (AW+1)'(1);
          if (idx_q == len_q - (AW+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && occ == 3'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    inflight_d = issue;
    ram_addr_d = issue ? (base_q + offset) : ram_addr_q;

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (inflight_q) begin
      fifo_d[wr_ptr_q] = ram_q;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      ram_addr_q <= '0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      ram_addr_q <= ram_addr_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_spram_rd_stream.sv
// Bench for spram_rd_stream: table-driven commands, reset abort sequence and
// randomized commands, all checked against an address-order/memory reference model.
module tb_spram_rd_stream;
  localparam int DW = 8;
  localparam int AW = 11;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, start, bitrev, m_ready;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          busy, done, ram_we, m_valid;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q, m_data;

  spram_rd_stream #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len), .bitrev(bitrev),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) ram_q <= mem[ram_addr];

  typedef struct {
    int       base;
    int       len;
    bit       bitrev;
    int       mode;       // 0 ready high, 1 pattern 1,0,0, 2 random, 3 low for 10 cycles
    bit       mid_start;
    bit       chain;      // start in the same cycle the previous done is seen
    int       exp_first;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_off(input int i, input int n, input bit br);
    bit en;
    int k, r;
    en = 1'b0;
`ifdef SPRAM_RD_BITREV_EN
    en = 1'b1;
`endif
    if (en && br && n >= 2 && (n & (n - 1)) == 0) begin
      k = $clog2(n);
      r = 0;
      for (int b = 0; b < k; b++) if (((i >> b) & 1) == 1) r += 1 << (k - 1 - b);
      return r;
    end
    return i;
  endfunction

  function automatic int model_addr(input vec_t v, input int i);
    return (v.base + model_off(i, v.len, v.bitrev)) % DEPTH;
  endfunction

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0: return 1'b1;
      1: return ((k - 1) % 3) == 0;
      2: return 1'($urandom_range(0, 1));
      3: return k > 10;
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_cmd(input vec_t v);
    int k, done_k, exp_done, beats, issued, ahead_max, budget;
    int stab_err, busy_err, we_err;
    logic [DW-1:0] prev_data;
    bit prev_stall, got_done;
    if (!v.chain) @(negedge clk);
    chk("idle_before_start", int'(busy), 0);
    start = 1'b1; base = AW'(v.base); len = (AW+1)'(v.len); bitrev = v.bitrev; m_ready = 1'b1;
    exp_done = (v.len == 0) ? 1 : v.len + 3;
    budget = 12 * v.len + 40;
    beats = 0; issued = 0; ahead_max = 0; stab_err = 0; busy_err = 0; we_err = 0;
    prev_stall = 1'b0; prev_data = '0; got_done = 1'b0; done_k = -1;
    k = 1;
    while (k <= budget && !got_done) begin
      @(negedge clk);
      start = v.mid_start && (k == 4);
      if (start) begin base = AW'(500); len = (AW+1)'(3); end
      m_ready = ready_for(v.mode, k);
      #1;
      if (ram_we) we_err++;
      if (issued < v.len && int'(ram_addr) == model_addr(v, issued)) issued++;
      if (prev_stall && (!m_valid || m_data !== prev_data)) stab_err++;
      if (m_valid && m_ready) begin
        chk("beat_data", int'(m_data), int'(mem[model_addr(v, beats)]));
        if (beats == 0) chk("first_word", int'(m_data), v.exp_first);
        if (v.mode == 0) chk("beat_cycle", k, beats + 3);
        beats++;
      end
      if (issued - beats > ahead_max) ahead_max = issued - beats;
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      if (v.mode == 0 && busy != (k < exp_done)) busy_err++;
      if (done) begin
        got_done = 1'b1;
        done_k = k;
        chk("busy_at_done", int'(busy), 0);
      end else if (!busy) busy_err++;
      k++;
    end
    start = 1'b0;
    chk("done_seen", int'(got_done), 1);
    if (v.mode == 0) chk("done_cycle", done_k, exp_done);
    chk("beat_count", beats, v.len);
    chk("issue_count", issued, v.len);
    chk("reads_ahead_le2", int'(ahead_max <= 2), 1);
    chk("stall_stable", stab_err, 0);
    chk("busy_window", busy_err, 0);
    chk("ram_we_zero", we_err, 0);
  endtask

  vec_t tbl [10];

  initial begin
    int beats, late_done;
    vec_t v;
    for (int a = 0; a < DEPTH; a++) mem[a] = DW'((a & 255) ^ (a >> 8));

    tbl[0] = '{base: 16,   len: 8, bitrev: 0, mode: 0, mid_start: 0, chain: 0, exp_first: 16};
    tbl[1] = '{base: 2046, len: 4, bitrev: 0, mode: 0, mid_start: 0, chain: 0, exp_first: 249};
    tbl[2] = '{base: 0,    len: 6, bitrev: 0, mode: 1, mid_start: 0, chain: 0, exp_first: 0};
    tbl[3] = '{base: 0,    len: 0, bitrev: 0, mode: 0, mid_start: 0, chain: 0, exp_first: 0};
    tbl[4] = '{base: 300,  len: 8, bitrev: 0, mode: 0, mid_start: 1, chain: 0, exp_first: 45};
    tbl[5] = '{base: 0,    len: 8, bitrev: 1, mode: 0, mid_start: 0, chain: 0, exp_first: 0};
    tbl[6] = '{base: 0,    len: 6, bitrev: 1, mode: 0, mid_start: 0, chain: 0, exp_first: 0};
    tbl[7] = '{base: 40,   len: 5, bitrev: 0, mode: 3, mid_start: 0, chain: 1, exp_first: 40};
    tbl[8] = '{base: 7,    len: 1, bitrev: 0, mode: 1, mid_start: 0, chain: 0, exp_first: 7};
    tbl[9] = '{base: 2040, len: 16, bitrev: 1, mode: 2, mid_start: 0, chain: 0, exp_first: 255};

    rst = 1'b1; start = 1'b0; bitrev = 1'b0; m_ready = 1'b0; base = '0; len = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_m_data", int'(m_data), 0);
    rst = 1'b0;

    for (int t = 0; t < 10; t++) run_cmd(tbl[t]);

    // Reset in the middle of an 8-word command, after 3 beats have transferred.
    @(negedge clk);
    start = 1'b1; base = AW'(100); len = (AW+1)'(8); bitrev = 1'b0; m_ready = 1'b1;
    beats = 0;
    for (int k = 1; k <= 20 && beats < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (m_valid && m_ready) beats++;
    end
    chk("pre_rst_beats", beats, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(m_valid), 0);
    chk("abort_done", int'(done), 0);
    rst = 1'b0;
    late_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      if (done || m_valid || busy) late_done++;
    end
    chk("abort_quiet", late_done, 0);
    v = '{base: 1000, len: 2, bitrev: 0, mode: 0, mid_start: 0, chain: 0, exp_first: 235};
    run_cmd(v);

    for (int r = 0; r < 25; r++) begin
      v.base = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 3) == 0) v.len = 1 << $urandom_range(1, 5);
      else if ($urandom_range(0, 6) == 0) v.len = $urandom_range(30, 70);
      else v.len = $urandom_range(0, 12);
      v.bitrev = 1'($urandom_range(0, 1));
      v.mode = $urandom_range(0, 3);
      v.mid_start = (v.len >= 2) && ($urandom_range(0, 3) == 0);
      v.chain = 1'($urandom_range(0, 1));
      v.exp_first = (v.len > 0) ? int'(mem[model_addr(v, 0)]) : 0;
      run_cmd(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spram_rd_stream.md
# spram_rd_stream

Streaming read controller for the single-port memory (`spram`) used in the FFT core. On a start command it issues a block of reads to the memory port, absorbs the memory's one-cycle registered-address read latency, and presents the words on a valid/ready output stream at up to one word per clock with full backpressure support. It sits between a sample/twiddle buffer and the downstream butterfly or output stage.

## Interface
- `DW`, 8: data width, matches memory `DW`.
- `AW`, 11: address width, matches memory `AW`; memory depth is 2^AW.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  command strobe; accepted only when `busy`=0.
- `base`  in  AW  first address, sampled with `start`.
- `len`  in  AW+1  word count, 0..2^AW, sampled with `start`.
- `bitrev`  in  1  bit-reversed order request, sampled with `start`; used only with `SPRAM_RD_BITREV_EN`.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle pulse at command completion.
- `ram_addr`  out  AW  to memory `addr`.
- `ram_we`  out  1  to memory `we`; constant 0.
- `ram_q`  in  DW  from memory `q`; holds ram[address presented in the previous cycle].
- `m_data`  out  DW  output word.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `start`=1 latches `base`, `len`, `bitrev`, clears index i. If `len`=0, go straight back to IDLE with `done` pulsed next cycle, no beats. Otherwise go to RUN.
- RUN: a read is issued in a cycle when credit is available: (FIFO occupancy + in-flight read − pop this cycle) < 2. Issue drives `ram_addr` = (base + offset(i)) mod 2^AW and increments i. After issuing read index `len`−1, go to DRAIN.
- DRAIN: wait until the in-flight read has landed and the FIFO is empty. Then return to IDLE and pulse `done`.
- The in-flight flag is registered. The word on `ram_q` in the cycle after an issue is pushed into a 2-entry output FIFO.
- Output: `m_valid` = FIFO non-empty; `m_data` = FIFO head. A beat transfers when `m_valid`&`m_ready`. `m_data` is stable while `m_valid`=1 and `m_ready`=0.
- offset(i) = i (linear). Address wrap-around is modulo 2^AW, e.g. base=2046, len=4 → 2046, 2047, 0, 1.
- `ram_addr` holds its last value when not issuing. The reread is harmless because `ram_we` is always 0.
- `start` while `busy`=1 is ignored.
- Reset values: state IDLE, `busy`=0, `done`=0, `m_valid`=0, `ram_addr`=0, `m_data`=0, FIFO empty, in-flight cleared. Reset mid-operation aborts the command immediately: the in-flight read is discarded and no `done` is pulsed.

## Timing
- `start` accepted at cycle T.
- `busy`=1 from T+1 through the cycle `done`=1 (exclusive).
- First `ram_addr` at T+1; data at `ram_q` at T+2; first `m_valid` at T+3.
- With `m_ready` held high: one beat per cycle, beats at T+3..T+2+len. `done` at T+3+len (the cycle after the last handshake).
- Backpressure: on `m_ready`=0, at most 2 words are buffered and issuing stalls. On `m_ready` returning to 1, beats are back-to-back with no bubble.
- A new `start` is accepted in the same cycle `done`=1.

## Configuration
- `SPRAM_RD_BITREV_EN` defined: if the latched `bitrev`=1 and `len`=2^k (k≥1), offset(i) = the k-bit reversal of i (FFT input reordering). If `len` is not a power of two, or `len`=1, the order is linear.
- Not defined: the `bitrev` port is present but ignored; order is always linear; no reversal logic is synthesised.

## Test plan
- Linear: mem[a]=a&0xFF, base=16, len=8, `m_ready`=1 → `m_data` 16..23 at T+3..T+10, `done` at T+11, `ram_we` never 1.
- Wrap: base=2046, len=4 → data at addresses 2046, 2047, 0, 1.
- Backpressure: base=0, len=6, `m_ready` toggling 1,0,0,1,… → every word exactly once in order, `m_data` stable during stalls, never more than 2 reads ahead.
- Zero length and busy: len=0 → `done` at T+1, no `m_valid`. `start` pulsed mid-command → ignored.
- Reset: `rst` asserted after 3 of 8 beats → next cycle `busy`=0, `m_valid`=0, no `done`. A new len=2 command after reset runs clean.
- Bit-reverse (macro defined): base=0, len=8, `bitrev`=1 → addresses 0,4,2,6,1,5,3,7. With len=6 the order is linear.
